// File: rtl/vecmat_dot_acc.sv
// vecmat_dot_acc: signed fixed-point dot product, LANES lanes per beat, saturating multi-beat accumulate.
// Latency: last accepted beat to out_valid = 2 + log2(LANES) cycles (multiply, adder tree, accumulate).
// Backpressure: while out_valid && !out_ready every stage holds and in_ready is low; no bubble on hand-over.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  input beat handshake; in_last marks the final chunk of a vector
//   vector, matrix     LANES signed elements each, lane i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready result handshake
//   data_out           saturated dot product in Qx.FRAC_W
//   out_ovf            saturation occurred somewhere in this vector
//   out_beats          number of beats summed into this result (saturating)
module vecmat_dot_acc #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LANES  = 64,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [LANES*DATA_W-1:0]   vector,
  input  logic [LANES*DATA_W-1:0]   matrix,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         data_out,
  output logic                      out_ovf,
  output logic [CNT_W-1:0]          out_beats
);

  localparam int LOG2L = $clog2(LANES);
  localparam int PW    = 2 * DATA_W;
  localparam int TW    = PW + LOG2L;

  localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] D_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  // A single global hold: the result register is the only place a stall can originate.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic signed [DATA_W-1:0] va [LANES];
  logic signed [DATA_W-1:0] ma [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      va[i] = vector[i*DATA_W +: DATA_W];
      ma[i] = matrix[i*DATA_W +: DATA_W];
    end
  end

  // Level 0 holds the registered products; level l holds LANES>>l partial sums
  // that are l bits wider than a product, so no bits are ever dropped.
  genvar l;
  generate
    for (l = 0; l <= LOG2L; l++) begin : g_lvl
      localparam int N = LANES >> l;
      localparam int W = PW + l;
      logic signed [W-1:0] node [N];
      logic                vld;
      logic                lst;

      if (l == 0) begin : g_mul
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            vld <= 1'b0;
            lst <= 1'b0;
          end else if (!stall) begin
            vld <= in_valid;
            lst <= in_last;
          end
        end

        always_ff @(posedge clk) begin
          if (!stall) begin
            for (int i = 0; i < N; i++) begin
              node[i] <= W'(va[i]) * W'(ma[i]);
            end
          end
        end
      end else begin : g_add
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            vld <= 1'b0;
            lst <= 1'b0;
          end else if (!stall) begin
            vld <= g_lvl[l-1].vld;
            lst <= g_lvl[l-1].lst;
          end
        end

        always_ff @(posedge clk) begin
          if (!stall) begin
            for (int i = 0; i < N; i++) begin
              node[i] <= W'(g_lvl[l-1].node[2*i]) + W'(g_lvl[l-1].node[2*i+1]);
            end
          end
        end
      end
    end
  endgenerate

  logic signed [TW-1:0] tree;
  logic                 t_vld;
  logic                 t_lst;
  assign tree  = g_lvl[LOG2L].node[0];
  assign t_vld = g_lvl[LOG2L].vld;
  assign t_lst = g_lvl[LOG2L].lst;

  logic signed [ACC_W-1:0]  acc;
  logic                     first;
  logic                     ovf;
  logic [CNT_W-1:0]         cnt;

  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W:0]    sum_w;
  logic signed [ACC_W-1:0]  sum_sat;
  logic signed [ACC_W-1:0]  sum_shr;
  logic [ACC_W-DATA_W:0]    hi;
  logic                     acc_ovf;
  logic                     out_sat;
  logic signed [DATA_W-1:0] res;
  logic [CNT_W-1:0]         cnt_nxt;

  always_comb begin
    acc_base = first ? '0 : acc;
    // One guard bit: the top two bits disagree exactly when ACC_W overflowed.
    sum_w    = (ACC_W+1)'(acc_base) + (ACC_W+1)'(tree);
    acc_ovf  = sum_w[ACC_W] != sum_w[ACC_W-1];
    if (!acc_ovf)          sum_sat = sum_w[ACC_W-1:0];
    else if (sum_w[ACC_W]) sum_sat = ACC_MIN;
    else                   sum_sat = ACC_MAX;

    // Arithmetic shift rounds toward -inf; the result fits DATA_W only if
    // every bit above the DATA_W sign bit matches it.
    sum_shr = sum_sat >>> FRAC_W;
    hi      = sum_shr[ACC_W-1:DATA_W-1];
    out_sat = !((hi == '0) || (hi == '1));
    if (!out_sat)               res = sum_shr[DATA_W-1:0];
    else if (sum_shr[ACC_W-1])  res = D_MIN;
    else                        res = D_MAX;

    cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      first     <= 1'b1;
      ovf       <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_ovf   <= 1'b0;
      out_beats <= '0;
    end else if (!stall) begin
      // Not stalled means the current result (if any) is being consumed now.
      out_valid <= t_vld && t_lst;
      if (t_vld) begin
        if (t_lst) begin
          data_out  <= res;
          out_ovf   <= ovf | acc_ovf | out_sat;
          out_beats <= cnt_nxt;
          acc       <= '0;
          first     <= 1'b1;
          ovf       <= 1'b0;
          cnt       <= '0;
        end else begin
          acc       <= sum_sat;
          first     <= 1'b0;
          ovf       <= ovf | acc_ovf;
          cnt       <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_vecmat_dot_acc.sv
// tb_vecmat_dot_acc: directed bench for vecmat_dot_acc with hand-computed expected results.
// Latency: expects a result 8 cycles after the accepting edge of the last beat.
// Backpressure: exercises a 5-cycle out_ready stall with a second result queued behind it.
module tb_vecmat_dot_acc;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int LANES  = 64;
  localparam int ACC_W  = 48;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic                    in_last = 1'b0;
  logic [LANES*DATA_W-1:0] vector = '0;
  logic [LANES*DATA_W-1:0] matrix = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [DATA_W-1:0]       data_out;
  logic                    out_ovf;
  logic [CNT_W-1:0]        out_beats;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  vecmat_dot_acc #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .vector(vector), .matrix(matrix),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_ovf(out_ovf), .out_beats(out_beats)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Drive one beat at a falling edge; all lanes get v/m except lane 0 which gets v0/m0.
  task automatic put(input logic [15:0] v, input logic [15:0] m,
                     input logic [15:0] v0, input logic [15:0] m0, input logic last);
    for (int i = 0; i < LANES; i++) begin
      vector[i*DATA_W +: DATA_W] = (i == 0) ? v0 : v;
      matrix[i*DATA_W +: DATA_W] = (i == 0) ? m0 : m;
    end
    in_valid = 1'b1;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // lat counts rising edges from the accepting edge (inclusive) to out_valid.
  task automatic wait_res(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic res_chk(input string tag, input logic [15:0] d, input logic o, input logic [7:0] b);
    chk({tag, "_data"},  32'(data_out),  32'(d));
    chk({tag, "_ovf"},   32'(out_ovf),   32'(o));
    chk({tag, "_beats"}, 32'(out_beats), 32'(b));
  endtask

  initial begin
    int lat;
    int extra;

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(data_out),  32'd0);
    chk("rst_ovf",   32'(out_ovf),   32'd0);
    chk("rst_beats", 32'(out_beats), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // 64 lanes of 1.0*1.0 = 64.0
    put(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1);
    wait_res("t1", lat);
    chk("t1_latency", 32'(lat), 32'd8);
    res_chk("t1", 16'h4000, 1'b0, 8'd1);
    @(negedge clk);
    chk("t1_drop", 32'(out_valid), 32'd0);

    // 128.0 does not fit Q8.8
    put(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0);
    put(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1);
    wait_res("t2", lat);
    res_chk("t2", 16'h7FFF, 1'b1, 8'd2);
    @(negedge clk);

    // 64 * (-1.0 * 2.0) = -128.0, exactly the most negative value
    put(16'hFF00, 16'h0200, 16'hFF00, 16'h0200, 1'b1);
    wait_res("t3", lat);
    res_chk("t3", 16'h8000, 1'b0, 8'd1);
    @(negedge clk);

    // lane 0 zeroed: 63 * -2.0 = -126.0
    put(16'hFF00, 16'h0200, 16'h0000, 16'h0200, 1'b1);
    wait_res("t4", lat);
    res_chk("t4", 16'h8200, 1'b0, 8'd1);
    @(negedge clk);

    // raw sum of -1 LSB^2 shifts to -1 (toward -inf), not 0
    put(16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 1'b1);
    wait_res("t5", lat);
    res_chk("t5", 16'hFFFF, 1'b0, 8'd1);
    @(negedge clk);

    // A (64.0) then B (-128.0) back to back, A held for 5 cycles
    out_ready = 1'b0;
    put(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1);
    put(16'hFF00, 16'h0200, 16'hFF00, 16'h0200, 1'b1);
    wait_res("t6a", lat);
    for (int k = 0; k < 5; k++) begin
      chk("t6_hold_valid", 32'(out_valid), 32'd1);
      chk("t6_hold_data",  32'(data_out),  32'h4000);
      chk("t6_hold_ready", 32'(in_ready),  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6b_valid", 32'(out_valid), 32'd1);
    res_chk("t6b", 16'h8000, 1'b0, 8'd1);
    extra = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("t6_no_dup", 32'(extra), 32'd0);

    // reset after beat 1 of a 3-beat vector discards the partial sum
    put(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("t7_rst_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    put(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1);
    wait_res("t7", lat);
    res_chk("t7", 16'h4000, 1'b0, 8'd1);
    @(negedge clk);

    // 3 beats: 64*(0.25 + 0.5 + 0.75) = 96.0
    put(16'h0040, 16'h0100, 16'h0040, 16'h0100, 1'b0);
    put(16'h0080, 16'h0100, 16'h0080, 16'h0100, 1'b0);
    put(16'h00C0, 16'h0100, 16'h00C0, 16'h0100, 1'b1);
    wait_res("t8", lat);
    res_chk("t8", 16'h6000, 1'b0, 8'd3);
    @(negedge clk);

    // same vector with two idle cycles between beats
    put(16'h0040, 16'h0100, 16'h0040, 16'h0100, 1'b0);
    repeat (2) @(negedge clk);
    put(16'h0080, 16'h0100, 16'h0080, 16'h0100, 1'b0);
    repeat (2) @(negedge clk);
    put(16'h00C0, 16'h0100, 16'h00C0, 16'h0100, 1'b1);
    wait_res("t9", lat);
    res_chk("t9", 16'h6000, 1'b0, 8'd3);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
